// File: rtl/gpio_pkg.sv
// Shared constants for the AHB GPIO: register word offsets, HTRANS encodings
// and CTRL bit positions.
package gpio_pkg;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_DIR     = 3'd1;
    localparam logic [2:0] REG_IE      = 3'd2;
    localparam logic [2:0] REG_IS      = 3'd3;
    localparam logic [2:0] REG_EDGE    = 3'd4;
    localparam logic [2:0] REG_CTRL    = 3'd5;
    localparam logic [2:0] REG_PERRCNT = 3'd6;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int CTRL_PAR_EN  = 0;
    localparam int CTRL_PAR_ODD = 1;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs.
module gpio_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ahb_gpio_param.sv
// Zero-wait-state AHB-Lite GPIO with per-bit direction, programmable parity
// on the pad word, parity-error counter and edge-triggered maskable interrupts.
module ahb_gpio_param
    import gpio_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int PERR_CNT_W  = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    input  logic [DATA_W:0]   GPIOIN,
    output logic [DATA_W:0]   GPIOOUT,
    output logic              PARITYERR,
    output logic              IRQ
);

    localparam int BLANK_W = $clog2(SYNC_STAGES + 2);
    localparam logic [BLANK_W-1:0] BLANK_RELOAD = BLANK_W'(SYNC_STAGES + 1);

    logic              addr_valid, dp_valid, dp_write;
    logic [2:0]        dp_addr;
    logic              wr_data, wr_dir, wr_ie, wr_is, wr_edge, wr_ctrl, wr_perr;
    logic [DATA_W-1:0] data_reg, dir_reg, ie_reg, is_reg, edge_reg, sync_prev;
    logic [DATA_W-1:0] data_next, dir_next, is_next, out_bits, rise, fall, edge_hit;
    logic [1:0]        ctrl_reg, ctrl_next;
    logic [DATA_W:0]   sync_in;
    logic [BLANK_W-1:0]    blank;
    logic [PERR_CNT_W-1:0] perr_cnt;
    logic              out_par, mismatch, perr_next;
    logic              unused_bits;

    assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HWDATA[31:DATA_W]};
    assign HREADYOUT   = 1'b1;

    assign addr_valid = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else begin
            dp_valid <= addr_valid;
            if (addr_valid) begin
                dp_write <= HWRITE;
                dp_addr  <= HADDR[4:2];
            end
        end
    end

    assign wr_data = dp_valid & dp_write & (dp_addr == REG_DATA);
    assign wr_dir  = dp_valid & dp_write & (dp_addr == REG_DIR);
    assign wr_ie   = dp_valid & dp_write & (dp_addr == REG_IE);
    assign wr_is   = dp_valid & dp_write & (dp_addr == REG_IS);
    assign wr_edge = dp_valid & dp_write & (dp_addr == REG_EDGE);
    assign wr_ctrl = dp_valid & dp_write & (dp_addr == REG_CTRL);
    assign wr_perr = dp_valid & dp_write & (dp_addr == REG_PERRCNT);

    gpio_sync #(.W(DATA_W + 1), .STAGES(SYNC_STAGES)) u_sync (
        .clk (HCLK),
        .rst (HRESET),
        .d   (GPIOIN),
        .q   (sync_in)
    );

    // Pad drive is computed from the post-write values so the output word and
    // its parity bit change on the same edge as the registers themselves.
    always_comb begin
        data_next = wr_data ? HWDATA[DATA_W-1:0] : data_reg;
        dir_next  = wr_dir  ? HWDATA[DATA_W-1:0] : dir_reg;
        ctrl_next = wr_ctrl ? HWDATA[1:0]        : ctrl_reg;
    end

    assign out_bits = data_next & dir_next;
    assign out_par  = ctrl_next[CTRL_PAR_EN] & ((^out_bits) ^ ctrl_next[CTRL_PAR_ODD]);

    assign rise     = sync_in[DATA_W-1:0] & ~sync_prev;
    assign fall     = ~sync_in[DATA_W-1:0] & sync_prev;
    assign edge_hit = (edge_reg & fall) | (~edge_reg & rise);
    // A fresh edge must survive a W1C landing in the same cycle.
    assign is_next  = (is_reg & ~(wr_is ? HWDATA[DATA_W-1:0] : '0)) | edge_hit;

    assign mismatch  = ctrl_reg[CTRL_PAR_EN] & ((^sync_in) ^ ctrl_reg[CTRL_PAR_ODD]);
    assign perr_next = mismatch & (blank == '0);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            data_reg  <= '0;
            dir_reg   <= '0;
            ie_reg    <= '0;
            is_reg    <= '0;
            edge_reg  <= '0;
            ctrl_reg  <= '0;
            sync_prev <= '0;
            GPIOOUT   <= '0;
            IRQ       <= 1'b0;
            PARITYERR <= 1'b0;
            blank     <= BLANK_RELOAD;
            perr_cnt  <= '0;
        end else begin
            data_reg  <= data_next;
            dir_reg   <= dir_next;
            ctrl_reg  <= ctrl_next;
            is_reg    <= is_next;
            sync_prev <= sync_in[DATA_W-1:0];
            GPIOOUT   <= {out_par, out_bits};
            IRQ       <= |(is_reg & ie_reg);
            PARITYERR <= perr_next;
            if (wr_ie)   ie_reg   <= HWDATA[DATA_W-1:0];
            if (wr_edge) edge_reg <= HWDATA[DATA_W-1:0];
            // Looped-back pads need SYNC_STAGES+1 cycles to settle after a change.
            if (wr_ctrl || wr_data) blank <= BLANK_RELOAD;
            else if (blank != '0)   blank <= blank - BLANK_W'(1);
            if (wr_perr)
                perr_cnt <= '0;
            else if (perr_next && !PARITYERR && !(&perr_cnt))
                perr_cnt <= perr_cnt + PERR_CNT_W'(1);
        end
    end

    always_comb begin
        HRDATA = '0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                REG_DATA:    HRDATA = 32'(sync_in[DATA_W-1:0]);
                REG_DIR:     HRDATA = 32'(dir_reg);
                REG_IE:      HRDATA = 32'(ie_reg);
                REG_IS:      HRDATA = 32'(is_reg);
                REG_EDGE:    HRDATA = 32'(edge_reg);
                REG_CTRL:    HRDATA = 32'(ctrl_reg);
                REG_PERRCNT: HRDATA = 32'(perr_cnt);
                default:     HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_gpio_param.sv
// Directed self-checking bench for ahb_gpio_param with a pad loopback path.
module tb_ahb_gpio_param;

    localparam logic [31:0] A_DATA = 32'h00, A_DIR  = 32'h04, A_IE   = 32'h08, A_IS = 32'h0C;
    localparam logic [31:0] A_EDGE = 32'h10, A_CTRL = 32'h14, A_PERR = 32'h18, A_UNM = 32'h1C;

    logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, PARITYERR, IRQ;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [16:0] GPIOIN, GPIOOUT, force_mask, drive_val;
    logic        loop_en;

    int n_checks = 0;
    int n_fails  = 0;
    int perr_cycles = 0;
    int perr_base;
    logic [31:0] rd, prev;

    assign GPIOIN = loop_en ? (GPIOOUT | force_mask) : drive_val;

    ahb_gpio_param dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .GPIOIN    (GPIOIN),
        .GPIOOUT   (GPIOOUT),
        .PARITYERR (PARITYERR),
        .IRQ       (IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) if (PARITYERR) perr_cycles <= perr_cycles + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wdata;
        @(posedge HCLK); #1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        rdata = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(addr, v);
        check_eq(tag, v, exp);
    endtask

    task automatic write_then_read(input logic [31:0] waddr, input logic [31:0] wdata,
                                   input logic [31:0] raddr, output logic [31:0] rdata);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = waddr;
        @(posedge HCLK); #1;
        HWDATA = wdata; HWRITE = 1'b0; HADDR = raddr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        rdata = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    logic [15:0] b2b_data [6] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8001, 16'h5555, 16'h7FFE};
    logic [1:0]  b2b_ctrl [6] = '{2'd3, 2'd1, 2'd0, 2'd3, 2'd1, 2'd3};

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HREADY = 1'b1; HWDATA = '0; loop_en = 1'b1; force_mask = '0; drive_val = '0;

        // Reset values
        wait_cycles(3);
        check_eq("rst_gpioout", 32'(GPIOOUT), 32'h0);
        check_eq("rst_irq", 32'(IRQ), 32'h0);
        check_eq("rst_perr", 32'(PARITYERR), 32'h0);
        check_eq("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        check_eq("rst_hrdata", HRDATA, 32'h0);
        HRESET = 1'b0;
        wait_cycles(1);
        for (int a = 0; a < 8; a++) read_check("rst_reg", 32'(a * 4), 32'h0);

        // Loopback with odd then even parity
        perr_base = perr_cycles;
        bus_write(A_CTRL, 32'h3);
        bus_write(A_DIR, 32'hFFFF);
        bus_write(A_DATA, 32'h0001);
        wait_cycles(4);
        check_eq("loop_out_odd", 32'(GPIOOUT), 32'h00001);
        read_check("loop_data", A_DATA, 32'h0001);
        bus_write(A_CTRL, 32'h1);
        wait_cycles(4);
        check_eq("loop_out_even", 32'(GPIOOUT), 32'h10001);
        wait_cycles(3);
        check_eq("loop_no_perr", 32'(perr_cycles - perr_base), 32'h0);

        // Parity fault injection and counter saturation
        bus_write(A_CTRL, 32'h3);
        bus_write(A_DATA, 32'h0000);
        wait_cycles(6);
        check_eq("fault_pre_perr", 32'(PARITYERR), 32'h0);
        check_eq("fault_pre_out", 32'(GPIOOUT), 32'h10000);
        bus_write(A_PERR, 32'h0);
        force_mask = 17'h00008;
        wait_cycles(6);
        check_eq("fault_perr", 32'(PARITYERR), 32'h1);
        read_check("perrcnt_one", A_PERR, 32'h1);
        for (int i = 0; i < 300; i++) begin
            force_mask = 17'h0;
            wait_cycles(5);
            force_mask = 17'h00008;
            wait_cycles(5);
        end
        read_check("perrcnt_sat", A_PERR, 32'hFF);
        bus_write(A_PERR, 32'h5A);
        read_check("perrcnt_clr", A_PERR, 32'h0);
        check_eq("perr_held", 32'(PARITYERR), 32'h1);
        bus_write(A_CTRL, 32'h0);
        wait_cycles(6);
        check_eq("paroff_perr", 32'(PARITYERR), 32'h0);
        check_eq("paroff_out", 32'(GPIOOUT), 32'h0);
        read_check("paroff_forced_in", A_DATA, 32'h0008);
        read_check("paroff_cnt_hold", A_PERR, 32'h0);
        force_mask = 17'h0;
        wait_cycles(5);

        // Edge interrupts
        loop_en = 1'b0;
        drive_val = 17'h0;
        wait_cycles(4);
        bus_write(A_EDGE, 32'h4);
        bus_write(A_IS, 32'hFFFF);
        bus_write(A_IE, 32'h4);
        drive_val = 17'h00004;
        wait_cycles(5);
        read_check("is_rise_ignored", A_IS, 32'h0);
        check_eq("irq_idle", 32'(IRQ), 32'h0);
        drive_val = 17'h0;
        wait_cycles(3);
        check_eq("irq_early", 32'(IRQ), 32'h0);
        wait_cycles(1);
        check_eq("irq_set", 32'(IRQ), 32'h1);
        read_check("is_fall", A_IS, 32'h4);
        bus_write(A_IS, 32'h4);
        wait_cycles(1);
        check_eq("irq_w1c", 32'(IRQ), 32'h0);
        read_check("is_w1c", A_IS, 32'h0);
        drive_val = 17'h00020;
        wait_cycles(5);
        read_check("is_without_ie", A_IS, 32'h20);
        check_eq("irq_masked", 32'(IRQ), 32'h0);
        bus_write(A_IS, 32'h20);
        drive_val = 17'h00024;
        wait_cycles(5);
        drive_val = 17'h00020;
        wait_cycles(1);
        bus_write(A_IS, 32'h4);
        read_check("is_coincident", A_IS, 32'h4);
        check_eq("irq_coincident", 32'(IRQ), 32'h1);

        // Direction mask and unmapped address
        loop_en = 1'b1;
        bus_write(A_DIR, 32'h00FF);
        bus_write(A_DATA, 32'hABCD);
        wait_cycles(4);
        check_eq("dir_mask_out", 32'(GPIOOUT), 32'h000CD);
        read_check("unmapped_raz", A_UNM, 32'h0);
        bus_write(A_UNM, 32'hFFFF_FFFF);
        read_check("unmapped_wi_dir", A_DIR, 32'h00FF);
        read_check("dir_mask_in", A_DATA, 32'h00CD);
        read_check("unmapped_raz2", A_UNM, 32'h0);

        // Back-to-back write/read with parity mode changes
        bus_write(A_DIR, 32'hFFFF);
        wait_cycles(5);
        prev = 32'hABCD;
        perr_base = perr_cycles;
        for (int i = 0; i < 6; i++) begin
            bus_write(A_CTRL, 32'(b2b_ctrl[i]));
            write_then_read(A_DATA, 32'(b2b_data[i]), A_DATA, rd);
            check_eq("b2b_read", rd, prev);
            prev = 32'(b2b_data[i]);
        end
        wait_cycles(5);
        read_check("b2b_final", A_DATA, prev);
        check_eq("b2b_no_perr", 32'(perr_cycles - perr_base), 32'h0);

        // Reset during a pending write data phase
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_DIR;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h1234;
        HRESET = 1'b1;
        wait_cycles(2);
        check_eq("rst_mid_out", 32'(GPIOOUT), 32'h0);
        check_eq("rst_mid_irq", 32'(IRQ), 32'h0);
        HRESET = 1'b0;
        wait_cycles(1);
        read_check("rst_mid_dir", A_DIR, 32'h0);
        read_check("rst_mid_is", A_IS, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
